// File: rtl/perf_stats.sv
// Retire-stage statistics collector: run-cycle, branch, taken-branch and jump counters
// plus the latched display-syscall value, all registered for the seven-segment driver.
module perf_stats #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             clear,
  input  logic             valid,
  input  logic             is_branch,
  input  logic             br_taken,
  input  logic             is_jump,
  input  logic             disp_we,
  input  logic [WIDTH-1:0] disp_data,
  input  logic             halt,
  output logic [WIDTH-1:0] SyscallOut,
  output logic [WIDTH-1:0] T_all,
  output logic [WIDTH-1:0] T_branch,
  output logic [WIDTH-1:0] T_suc,
  output logic [WIDTH-1:0] T_jump,
  output logic             running,
  output logic             halted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sys_d, all_d, branch_d, suc_d, jump_d;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b1}}) ? v : v + WIDTH'(1);
  endfunction

  // Next-state and next-counter logic; clear overrides everything else.
  always_comb begin
    state_d  = state_q;
    sys_d    = SyscallOut;
    all_d    = T_all;
    branch_d = T_branch;
    suc_d    = T_suc;
    jump_d   = T_jump;
    if (clear) begin
      state_d  = IDLE;
      sys_d    = '0;
      all_d    = '0;
      branch_d = '0;
      suc_d    = '0;
      jump_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) state_d = RUN;
        end
        RUN: begin
          all_d = sat_inc(T_all);
          if (valid && is_branch) begin
            branch_d = sat_inc(T_branch);
            if (br_taken) suc_d = sat_inc(T_suc);
          end
          if (valid && is_jump) jump_d = sat_inc(T_jump);
          if (valid && disp_we) sys_d = disp_data;
          if (valid && halt) state_d = HALT;
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers; status flags decoded from the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      SyscallOut <= '0;
      T_all      <= '0;
      T_branch   <= '0;
      T_suc      <= '0;
      T_jump     <= '0;
      running    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state_q    <= state_d;
      SyscallOut <= sys_d;
      T_all      <= all_d;
      T_branch   <= branch_d;
      T_suc      <= suc_d;
      T_jump     <= jump_d;
      running    <= (state_d == RUN);
      halted     <= (state_d == HALT);
    end
  end

endmodule
